sha256_nonce_ctrl: RTL

- Mining sequencer directly upstream and downstream of sha256_core: drives its block/enable/digest inputs and consumes digest_out and valid_1/2/3.
- Takes an 80-byte block header, a nonce range and a 256-bit target. Runs the three-stage double hash once per nonce.
- Compares each final hash against the target and reports the first golden nonce, or reports range exhaustion.

---
 rtl/sha256_pkg.sv | 43 ++++
 rtl/sha256_target_cmp.sv | 20 ++
 rtl/sha256_nonce_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 mining sequencer: widths, header field
// offsets, the SHA-256 initial hash value, the sequencer state encoding and
// a byte-reversal helper.
package sha256_pkg;

    localparam int HEADER_W  = 640;
    localparam int DIGEST_W  = 256;
    localparam int BLOCK_W   = 512;
    localparam int NONCE_W   = 32;

    // Nonce occupies the last four header bytes; the 12 bytes above it are
    // the tail that goes into the second 512-bit block.
    localparam int NONCE_LSB = 0;
    localparam int TAIL_MSB  = 127;

    localparam logic [DIGEST_W-1:0] SHA256_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD1,
        ST_LOAD2,
        ST_H1,
        ST_W1,
        ST_H2,
        ST_W2,
        ST_H3,
        ST_W3,
        ST_CHECK,
        ST_FIN
    } state_t;

    // Reverse byte order of a digest (byte 0 <-> byte 31).
    function automatic logic [DIGEST_W-1:0] byte_reverse(input logic [DIGEST_W-1:0] d);
        logic [DIGEST_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGEST_W / 8; i++) begin
            r[i*8 +: 8] = d[DIGEST_W-8-i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_target_cmp.sv
// Combinational hash-versus-target check: optional byte reversal of the
// core digest followed by an unsigned 256-bit less-or-equal compare.
module sha256_target_cmp
    import sha256_pkg::*;
#(
    parameter bit BYTE_REVERSE = 1'b1
) (
    input  logic [DIGEST_W-1:0] digest,
    input  logic [DIGEST_W-1:0] target,
    output logic [DIGEST_W-1:0] hash,
    output logic                pass
);

    // Reorder the digest into comparison order and test against the target.
    always_comb begin
        hash = BYTE_REVERSE ? byte_reverse(digest) : digest;
        pass = (hash <= target);
    end

endmodule

// File: rtl/sha256_nonce_ctrl.sv
// Mining sequencer around sha256_core: loads the 80-byte header as two
// blocks, steps the core through the three-stage double hash for each nonce
// of an inclusive (wrapping) range and reports the first nonce whose hash is
// at or below the target.
module sha256_nonce_ctrl
    import sha256_pkg::*;
#(
    parameter int TIMEOUT        = 1024,
    parameter bit BYTE_REVERSE   = 1'b1,
    parameter bit REUSE_MIDSTATE = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 abort,
    input  logic [HEADER_W-1:0]  header_in,
    input  logic [NONCE_W-1:0]   nonce_start,
    input  logic [NONCE_W-1:0]   nonce_end,
    input  logic [DIGEST_W-1:0]  target,
    output logic [BLOCK_W-1:0]   core_block_in,
    output logic                 core_block_in_1_en,
    output logic                 core_block_in_2_en,
    output logic                 core_write_1_en,
    output logic                 core_write_2_en,
    output logic                 core_write_3_en,
    output logic [DIGEST_W-1:0]  core_digest_in,
    input  logic [DIGEST_W-1:0]  core_digest_out,
    input  logic                 core_valid_1,
    input  logic                 core_valid_2,
    input  logic                 core_valid_3,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic                 error,
    output logic [NONCE_W-1:0]   golden_nonce,
    output logic [DIGEST_W-1:0]  hash_out,
    output logic [31:0]          hash_count
);

    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int HDR_LSB = NONCE_LSB + NONCE_W;

    state_t                    state_q, state_d;
    logic                      first_q, first_d;
    logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic [HEADER_W-1:HDR_LSB] header_q, header_d;
    logic [DIGEST_W-1:0]       target_q, target_d;
    logic [NONCE_W-1:0]        nonce_q, nonce_d;
    logic [NONCE_W-1:0]        nonce_end_q, nonce_end_d;
    logic [DIGEST_W-1:0]       digest_q, digest_d;

    logic [BLOCK_W-1:0]        block_q, block_d;
    logic                      blk1_en_q, blk1_en_d;
    logic                      blk2_en_q, blk2_en_d;
    logic                      wr1_en_q, wr1_en_d;
    logic                      wr2_en_q, wr2_en_d;
    logic                      wr3_en_q, wr3_en_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      found_q, found_d;
    logic                      error_q, error_d;
    logic [NONCE_W-1:0]        golden_q, golden_d;
    logic [DIGEST_W-1:0]       hash_out_q, hash_out_d;
    logic [31:0]               hash_count_q, hash_count_d;

    logic [DIGEST_W-1:0]       cmp_hash;
    logic                      cmp_pass;
    logic                      timeout_hit;

    // The nonce field of the incoming header is always overwritten.
    logic unused_nonce_field;
    assign unused_nonce_field = ^header_in[HDR_LSB-1:NONCE_LSB];

    sha256_target_cmp #(
        .BYTE_REVERSE (BYTE_REVERSE)
    ) u_cmp (
        .digest (digest_q),
        .target (target_q),
        .hash   (cmp_hash),
        .pass   (cmp_pass)
    );

    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        wait_cnt_d   = wait_cnt_q;
        header_d     = header_q;
        target_d     = target_q;
        nonce_d      = nonce_q;
        nonce_end_d  = nonce_end_q;
        digest_d     = digest_q;
        block_d      = block_q;
        blk1_en_d    = 1'b0;
        blk2_en_d    = 1'b0;
        wr1_en_d     = 1'b0;
        wr2_en_d     = 1'b0;
        wr3_en_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        found_d      = found_q;
        error_d      = error_q;
        golden_d     = golden_q;
        hash_out_d   = hash_out_q;
        hash_count_d = hash_count_q;

        if (abort && (state_q != ST_IDLE)) begin
            // Abort beats anything else the current state would do.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        header_d     = header_in[HEADER_W-1:HDR_LSB];
                        target_d     = target;
                        nonce_d      = nonce_start;
                        nonce_end_d  = nonce_end;
                        first_d      = 1'b1;
                        found_d      = 1'b0;
                        error_d      = 1'b0;
                        golden_d     = '0;
                        hash_out_d   = '0;
                        hash_count_d = '0;
                        busy_d       = 1'b1;
                        state_d      = ST_LOAD1;
                    end
                end
                ST_LOAD1: begin
                    block_d   = header_q[HEADER_W-1 -: BLOCK_W];
                    blk1_en_d = 1'b1;
                    state_d   = ST_LOAD2;
                end
                ST_LOAD2: begin
                    block_d   = {header_q[TAIL_MSB:HDR_LSB], nonce_q,
                                 {(BLOCK_W - (TAIL_MSB + 1)){1'b0}}};
                    blk2_en_d = 1'b1;
                    first_d   = 1'b0;
                    state_d   = (first_q || !REUSE_MIDSTATE) ? ST_H1 : ST_H2;
                end
                ST_H1: begin
                    wr1_en_d   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_W1;
                end
                ST_W1: begin
                    if (core_valid_1) begin
                        state_d = ST_H2;
                    end else if (timeout_hit) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                ST_H2: begin
                    wr2_en_d   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_W2;
                end
                ST_W2: begin
                    if (core_valid_2) begin
                        state_d = ST_H3;
                    end else if (timeout_hit) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                ST_H3: begin
                    wr3_en_d   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_W3;
                end
                ST_W3: begin
                    if (core_valid_3) begin
                        digest_d = core_digest_out;
                        state_d  = ST_CHECK;
                    end else if (timeout_hit) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    hash_count_d = hash_count_q + 32'd1;
                    if (cmp_pass) begin
                        found_d    = 1'b1;
                        golden_d   = nonce_q;
                        hash_out_d = cmp_hash;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_FIN;
                    end else if (nonce_q == nonce_end_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        // Natural 32-bit wrap lets a range pass through zero.
                        nonce_d = nonce_q + 32'd1;
                        state_d = REUSE_MIDSTATE ? ST_LOAD2 : ST_LOAD1;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Control state and all registered outputs; cleared by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            first_q      <= 1'b0;
            wait_cnt_q   <= '0;
            block_q      <= '0;
            blk1_en_q    <= 1'b0;
            blk2_en_q    <= 1'b0;
            wr1_en_q     <= 1'b0;
            wr2_en_q     <= 1'b0;
            wr3_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            error_q      <= 1'b0;
            golden_q     <= '0;
            hash_out_q   <= '0;
            hash_count_q <= '0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            wait_cnt_q   <= wait_cnt_d;
            block_q      <= block_d;
            blk1_en_q    <= blk1_en_d;
            blk2_en_q    <= blk2_en_d;
            wr1_en_q     <= wr1_en_d;
            wr2_en_q     <= wr2_en_d;
            wr3_en_q     <= wr3_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            found_q      <= found_d;
            error_q      <= error_d;
            golden_q     <= golden_d;
            hash_out_q   <= hash_out_d;
            hash_count_q <= hash_count_d;
        end
    end

    // Run operands latched at start and the captured digest; always
    // written before they are read, so they carry no reset.
    always_ff @(posedge CLK) begin
        header_q    <= header_d;
        target_q    <= target_d;
        nonce_q     <= nonce_d;
        nonce_end_q <= nonce_end_d;
        digest_q    <= digest_d;
    end

    assign core_block_in      = block_q;
    assign core_block_in_1_en = blk1_en_q;
    assign core_block_in_2_en = blk2_en_q;
    assign core_write_1_en    = wr1_en_q;
    assign core_write_2_en    = wr2_en_q;
    assign core_write_3_en    = wr3_en_q;
    assign core_digest_in     = SHA256_IV;
    assign busy               = busy_q;
    assign done               = done_q;
    assign found              = found_q;
    assign error              = error_q;
    assign golden_nonce       = golden_q;
    assign hash_out           = hash_out_q;
    assign hash_count         = hash_count_q;

endmodule
